// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Inter-stage pipeline register for the five-stage MIPS core. Carries the
// instruction word, PC, branch-delay flag, exception code, T_new and a packed
// payload through DEPTH chained slots. The outputs are the contents of the
// last slot, so they are always registered.
//
// Per-cycle priority (highest first): reset > req > hold > stall > advance.
//   reset : async clear of every slot (pc included).
//   req   : every slot becomes a flush bubble whose pc is EXC_VEC.
//   hold  : whole chain frozen (stall ignored).
//   stall : slot 0 becomes a bubble that still records in_pc/in_bd so that
//           EPC/BD stay correct if an interrupt lands on the bubble; the
//           remaining slots advance.
//   advance: slot 0 loads the inputs, slot k loads slot k-1; tnew is
//           saturating-decremented on every move.
//
// Parameters:
//   PW      payload width (1..256)
//   TW      T_new width
//   DEPTH   number of chained slots (1..4)
//   EXC_VEC PC loaded into every slot on flush
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   req, hold, stall           flush, freeze chain, bubble into slot 0
//   in_valid/ins/pc/bd/exc/tnew/payload    incoming stage data
//   out_valid/ins/pc/bd/exc/tnew/payload   contents of slot DEPTH-1
//
// Optional feature (macro PIPE_STAGE_PERF_EN):
//   bubble_cnt  counts cycles with stall & ~hold & ~req
//   flush_cnt   counts cycles with req
//   Both 32-bit, wrap, async reset, not cleared by req.
//
// Handshake: there is no backpressure handshake; in_valid qualifies the
// incoming data and out_valid qualifies the last slot. Downstream stalling is
// expressed only through hold, which freezes every slot in place.
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int          PW      = 96,
  parameter int          TW      = 3,
  parameter int          DEPTH   = 1,
  parameter logic [31:0] EXC_VEC = 32'h0000_4180
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          hold,
  input  logic          stall,
  input  logic          in_valid,
  input  logic [31:0]   in_ins,
  input  logic [31:0]   in_pc,
  input  logic          in_bd,
  input  logic [4:0]    in_exc,
  input  logic [TW-1:0] in_tnew,
  input  logic [PW-1:0] in_payload,
  output logic          out_valid,
  output logic [31:0]   out_ins,
  output logic [31:0]   out_pc,
  output logic          out_bd,
  output logic [4:0]    out_exc,
  output logic [TW-1:0] out_tnew,
  output logic [PW-1:0] out_payload
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]   bubble_cnt,
  output logic [31:0]   flush_cnt
`endif
);

  // Saturating decrement: a result already available (0) stays at 0.
  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] x);
    return (x != '0) ? (x - TW'(1)) : '0;
  endfunction

  logic          slot_valid   [DEPTH];
  logic [31:0]   slot_ins     [DEPTH];
  logic [31:0]   slot_pc      [DEPTH];
  logic          slot_bd      [DEPTH];
  logic [4:0]    slot_exc     [DEPTH];
  logic [TW-1:0] slot_tnew    [DEPTH];
  logic [PW-1:0] slot_payload [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_valid[k]   <= 1'b0;
        slot_ins[k]     <= '0;
        slot_pc[k]      <= '0;
        slot_bd[k]      <= 1'b0;
        slot_exc[k]     <= '0;
        slot_tnew[k]    <= '0;
        slot_payload[k] <= '0;
      end
    end else if (req) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_valid[k]   <= 1'b0;
        slot_ins[k]     <= '0;
        slot_pc[k]      <= EXC_VEC;
        slot_bd[k]      <= 1'b0;
        slot_exc[k]     <= '0;
        slot_tnew[k]    <= '0;
        slot_payload[k] <= '0;
      end
    end else if (!hold) begin
      if (stall) begin
        // Bubble keeps pc/bd so an interrupt taken here reports a sane EPC.
        slot_valid[0]   <= 1'b0;
        slot_ins[0]     <= '0;
        slot_pc[0]      <= in_pc;
        slot_bd[0]      <= in_bd;
        slot_exc[0]     <= '0;
        slot_tnew[0]    <= '0;
        slot_payload[0] <= '0;
      end else begin
        slot_valid[0]   <= in_valid;
        slot_ins[0]     <= in_ins;
        slot_pc[0]      <= in_pc;
        slot_bd[0]      <= in_bd;
        slot_exc[0]     <= in_exc;
        slot_tnew[0]    <= sat_dec(in_tnew);
        slot_payload[0] <= in_payload;
      end
      for (int k = 1; k < DEPTH; k++) begin
        slot_valid[k]   <= slot_valid[k-1];
        slot_ins[k]     <= slot_ins[k-1];
        slot_pc[k]      <= slot_pc[k-1];
        slot_bd[k]      <= slot_bd[k-1];
        slot_exc[k]     <= slot_exc[k-1];
        slot_tnew[k]    <= sat_dec(slot_tnew[k-1]);
        slot_payload[k] <= slot_payload[k-1];
      end
    end
  end

  assign out_valid   = slot_valid[DEPTH-1];
  assign out_ins     = slot_ins[DEPTH-1];
  assign out_pc      = slot_pc[DEPTH-1];
  assign out_bd      = slot_bd[DEPTH-1];
  assign out_exc     = slot_exc[DEPTH-1];
  assign out_tnew    = slot_tnew[DEPTH-1];
  assign out_payload = slot_payload[DEPTH-1];

`ifdef PIPE_STAGE_PERF_EN
  // Counters survive flushes on purpose: they measure flush/bubble activity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (stall && !hold && !req) bubble_cnt <= bubble_cnt + 32'd1;
      if (req)                    flush_cnt  <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// Bench for pipe_stage_reg. Four instances (DEPTH 1..4, PW=16, TW=3) share
// one set of inputs; each check looks at the instance whose depth matters.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared inputs ----------------
  logic        req, hold, stall, in_valid, in_bd;
  logic [31:0] in_ins, in_pc;
  logic [4:0]  in_exc;
  logic [2:0]  in_tnew;
  logic [15:0] in_payload;

  // ---------------- per-instance outputs (index = DEPTH-1) ----------------
  logic        ov   [4];
  logic [31:0] oins [4];
  logic [31:0] opc  [4];
  logic        obd  [4];
  logic [4:0]  oexc [4];
  logic [2:0]  otn  [4];
  logic [15:0] opl  [4];
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] bc [4];
  logic [31:0] fc [4];
`endif

  for (genvar g = 0; g < 4; g++) begin : g_dut
    pipe_stage_reg #(
      .PW(16), .TW(3), .DEPTH(g + 1), .EXC_VEC(32'h0000_4180)
    ) dut (
      .clk(clk), .reset(reset), .req(req), .hold(hold), .stall(stall),
      .in_valid(in_valid), .in_ins(in_ins), .in_pc(in_pc), .in_bd(in_bd),
      .in_exc(in_exc), .in_tnew(in_tnew), .in_payload(in_payload),
      .out_valid(ov[g]), .out_ins(oins[g]), .out_pc(opc[g]), .out_bd(obd[g]),
      .out_exc(oexc[g]), .out_tnew(otn[g]), .out_payload(opl[g])
`ifdef PIPE_STAGE_PERF_EN
      , .bubble_cnt(bc[g]), .flush_cnt(fc[g])
`endif
    );
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare all fields of one instance against expectations.
  task automatic chk_out(input string tag, input int d, input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic bd, input logic [4:0] exc,
                         input logic [2:0] tn, input logic [15:0] pl);
    chk({tag, " valid"},   64'(ov[d]),   64'(v));
    chk({tag, " ins"},     64'(oins[d]), 64'(ins));
    chk({tag, " pc"},      64'(opc[d]),  64'(pc));
    chk({tag, " bd"},      64'(obd[d]),  64'(bd));
    chk({tag, " exc"},     64'(oexc[d]), 64'(exc));
    chk({tag, " tnew"},    64'(otn[d]),  64'(tn));
    chk({tag, " payload"}, 64'(opl[d]),  64'(pl));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic h, input logic s, input logic v,
                       input logic [31:0] ins, input logic [31:0] pc, input logic bd,
                       input logic [4:0] exc, input logic [2:0] tn, input logic [15:0] pl);
    req = r; hold = h; stall = s; in_valid = v; in_ins = ins; in_pc = pc;
    in_bd = bd; in_exc = exc; in_tnew = tn; in_payload = pl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 5'd0, 3'd0, 16'h0);
  endtask

  // Advance one edge, then sample just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table (DEPTH=1 instance) ----------------
  typedef struct {
    logic r, h, s, v;
    logic [31:0] ins, pc;
    logic bd;
    logic [4:0] exc;
    logic [2:0] tn;
    logic [15:0] pl;
    logic e_v;
    logic [31:0] e_ins, e_pc;
    logic e_bd;
    logic [4:0] e_exc;
    logic [2:0] e_tn;
    logic [15:0] e_pl;
  } vec_t;

  vec_t vecs [8];

  initial begin
    //           r  h  s  v  ins           pc            bd exc tn pl        | e_v e_ins         e_pc          bd exc tn pl
    vecs[0] = '{0, 0, 0, 1, 32'h2001_0005, 32'h0000_3000, 0, 0,  2, 16'h1234, 1, 32'h2001_0005, 32'h0000_3000, 0, 0,  1, 16'h1234};
    // hold wins over stall and new inputs
    vecs[1] = '{0, 1, 1, 1, 32'hDEAD_0000, 32'h0000_3004, 1, 7,  3, 16'h5555, 1, 32'h2001_0005, 32'h0000_3000, 0, 0,  1, 16'h1234};
    // stall bubble keeps pc/bd
    vecs[2] = '{0, 0, 1, 1, 32'h8C01_0004, 32'h0000_3010, 1, 3,  2, 16'hFFFF, 0, 32'h0,          32'h0000_3010, 1, 0,  0, 16'h0};
    // flush beats hold and stall
    vecs[3] = '{1, 1, 1, 1, 32'h1111_1111, 32'h0000_3014, 1, 9,  5, 16'hBEEF, 0, 32'h0,          32'h0000_4180, 0, 0,  0, 16'h0};
    // tnew of 0 stays 0
    vecs[4] = '{0, 0, 0, 1, 32'h1000_FFFF, 32'h0000_3020, 1, 4,  0, 16'hA5A5, 1, 32'h1000_FFFF, 32'h0000_3020, 1, 4,  0, 16'hA5A5};
    // invalid advance still carries data
    vecs[5] = '{0, 0, 0, 0, 32'hAAAA_5555, 32'h0000_3024, 0, 31, 7, 16'h0001, 0, 32'hAAAA_5555, 32'h0000_3024, 0, 31, 6, 16'h0001};
    // plain flush
    vecs[6] = '{1, 0, 0, 1, 32'h2222_2222, 32'h0000_3028, 1, 2,  4, 16'h7777, 0, 32'h0,          32'h0000_4180, 0, 0,  0, 16'h0};
    vecs[7] = '{0, 0, 0, 1, 32'h0C00_0100, 32'h0000_302C, 0, 0,  1, 16'h00FF, 1, 32'h0C00_0100, 32'h0000_302C, 0, 0,  0, 16'h00FF};
  end

  // ---------------- main test ----------------
  initial begin
    idle();
    reset = 1'b1;
    tick();
    for (int d = 0; d < 4; d++) chk_out($sformatf("reset d%0d", d + 1), d, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Table-driven sequence on DEPTH=1
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].r, vecs[i].h, vecs[i].s, vecs[i].v, vecs[i].ins, vecs[i].pc,
            vecs[i].bd, vecs[i].exc, vecs[i].tn, vecs[i].pl);
      tick();
      chk_out($sformatf("vec%0d", i), 0, vecs[i].e_v, vecs[i].e_ins, vecs[i].e_pc,
              vecs[i].e_bd, vecs[i].e_exc, vecs[i].e_tn, vecs[i].e_pl);
    end

    // DEPTH=2 now shows vec6's flush bubble (pc=EXC_VEC); check it first.
    chk("pre-reset d2 pc", 64'(opc[1]), 64'h4180);

    // Async reset between edges clears outputs with no clock edge.
    idle();
    #2;
    reset = 1'b1;
    #1;
    chk_out("async reset d2", 1, 0, 0, 0, 0, 0, 0, 0);
    chk_out("async reset d4", 3, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Two-edge latency on DEPTH=2, tnew 2 -> 1 -> 0.
    drive(0, 0, 0, 1, 32'h0, 32'h0000_3000, 0, 5'd0, 3'd2, 16'h0);
    tick();
    idle();
    chk("lat d2 edge1 pc", 64'(opc[1]), 64'h0);
    chk("lat d2 edge1 valid", 64'(ov[1]), 64'h0);
    tick();
    chk("lat d2 pc", 64'(opc[1]), 64'h3000);
    chk("lat d2 valid", 64'(ov[1]), 64'h1);
    chk("lat d2 tnew", 64'(otn[1]), 64'h0);

    // Hold on DEPTH=3 with three instructions in flight.
    drive(0, 0, 0, 1, 32'h1, 32'h0000_3000, 0, 5'd0, 3'd5, 16'h0); tick();
    drive(0, 0, 0, 1, 32'h2, 32'h0000_3004, 0, 5'd0, 3'd0, 16'h0); tick();
    drive(0, 0, 0, 1, 32'h3, 32'h0000_3008, 0, 5'd0, 3'd0, 16'h0); tick();
    chk("hold pre pc", 64'(opc[2]), 64'h3000);
    chk("hold pre tnew", 64'(otn[2]), 64'h2);
    drive(0, 1, 1, 1, 32'h4, 32'h0000_300C, 0, 5'd0, 3'd0, 16'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("hold c%0d pc", c), 64'(opc[2]), 64'h3000);
      chk($sformatf("hold c%0d tnew", c), 64'(otn[2]), 64'h2);
    end
    drive(0, 0, 0, 1, 32'h4, 32'h0000_300C, 0, 5'd0, 3'd0, 16'h0);
    tick();
    chk("release pc1", 64'(opc[2]), 64'h3004);
    tick();
    chk("release pc2", 64'(opc[2]), 64'h3008);

    // Saturation on DEPTH=4: in_tnew 0, 7, 3 -> out 0, 3, 0.
    drive(0, 0, 0, 1, 32'h0, 32'h0000_5000, 0, 5'd0, 3'd0, 16'h0); tick();
    drive(0, 0, 0, 1, 32'h0, 32'h0000_5004, 0, 5'd0, 3'd7, 16'h0); tick();
    drive(0, 0, 0, 1, 32'h0, 32'h0000_5008, 0, 5'd0, 3'd3, 16'h0); tick();
    idle(); tick();
    chk("sat t0 pc", 64'(opc[3]), 64'h5000);
    chk("sat t0 tnew", 64'(otn[3]), 64'h0);
    tick();
    chk("sat t7 pc", 64'(opc[3]), 64'h5004);
    chk("sat t7 tnew", 64'(otn[3]), 64'h3);
    tick();
    chk("sat t3 pc", 64'(opc[3]), 64'h5008);
    chk("sat t3 tnew", 64'(otn[3]), 64'h0);

`ifdef PIPE_STAGE_PERF_EN
    // Counters: clear, then one bubble cycle, one flush cycle, one held stall.
    #2;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    chk("perf reset bubble", 64'(bc[0]), 64'h0);
    chk("perf reset flush", 64'(fc[0]), 64'h0);
    drive(0, 0, 1, 1, 32'h0, 32'h0000_3010, 0, 5'd0, 3'd0, 16'h0); tick();
    chk("perf stall bubble", 64'(bc[0]), 64'h1);
    chk("perf stall flush", 64'(fc[0]), 64'h0);
    drive(1, 1, 1, 1, 32'h0, 32'h0000_3010, 0, 5'd0, 3'd0, 16'h0); tick();
    chk("perf req bubble", 64'(bc[0]), 64'h1);
    chk("perf req flush", 64'(fc[0]), 64'h1);
    drive(0, 1, 1, 1, 32'h0, 32'h0000_3010, 0, 5'd0, 3'd0, 16'h0); tick();
    chk("perf hold bubble", 64'(bc[0]), 64'h1);
    idle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the exception-capable five-stage MIPS core. It carries instruction word, PC, branch-delay flag, exception code, T_new and a packed payload of configurable width through DEPTH chained register slots. It supports exception flush to a vector, bubble insertion on hazard stall, and a whole-chain hold for multi-cycle downstream units. It replaces the hand-written per-stage registers (D/E, E/M, M/W) with one block instantiated per boundary.

## Interface
Parameters:
- PW, 96, payload width (packed imm/A/B/rs/rt/rd/control flags), 1..256
- TW, 3, T_new width
- DEPTH, 1, number of chained slots, 1..4
- EXC_VEC, 32'h0000_4180, PC loaded on flush

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears every slot immediately
- req  in  1  exception/interrupt flush
- hold  in  1  freeze entire chain
- stall  in  1  insert bubble into slot 0
- in_valid  in  1  incoming instruction valid
- in_ins  in  32  instruction word
- in_pc  in  32  instruction PC
- in_bd  in  1  branch-delay-slot flag
- in_exc  in  5  exception code (0 = none)
- in_tnew  in  TW  cycles until result available
- in_payload  in  PW  packed stage data
- out_valid, out_ins, out_pc, out_bd, out_exc, out_tnew, out_payload  out  widths as inputs  contents of slot DEPTH-1

## Operation
- Each slot holds {valid, ins, pc, bd, exc, tnew, payload}. Slot k>0 loads from slot k-1; slot 0 loads from the inputs.
- Per-cycle priority, highest first: reset > req > hold > stall > advance.
- reset (async): all slots valid=0, ins=0, pc=0, bd=0, exc=0, tnew=0, payload=0.
- req: all slots become flush bubbles: valid=0, ins=0, bd=0, exc=0, tnew=0, payload=0, pc=EXC_VEC.
- hold (no req): every slot keeps its contents, including tnew. stall is ignored.
- stall (no req, no hold): slot 0 becomes a stall bubble: valid=0, ins=0, exc=0, tnew=0, payload=0, but pc=in_pc and bd=in_bd are kept so EPC/BD remain correct if an interrupt hits a bubble. Slots 1..DEPTH-1 advance normally.
- advance: slot 0 loads the inputs, with valid=in_valid and tnew=sat_dec(in_tnew). Slot k loads slot k-1 with tnew=sat_dec(slot k-1 tnew).
- sat_dec(x) = x-1 if x≥1, else 0. Computed at TW bits with no wrap.
- Bubbles travel down the chain unchanged except for tnew, which stays 0.

## Timing
- Latency: DEPTH cycles from input to out_* when no hold occurs. Each hold cycle adds one cycle.
- Outputs are registered only. No combinational path from inputs to outputs.
- reset asserted mid-operation: outputs clear without waiting for clk. The first capture happens on the first rising edge after reset deasserts.
- req and stall in the same cycle: flush. req and hold in the same cycle: flush.
- An input tnew of 0 stays 0. With DEPTH=4 and in_tnew=3, the output tnew reads 2, 1, 0, 0 across slots 0..3.

## Configuration
- PIPE_STAGE_PERF_EN defined:
  - Adds outputs bubble_cnt (out, 32) and flush_cnt (out, 32).
  - bubble_cnt increments on each cycle with stall & ~hold & ~req.
  - flush_cnt increments on each cycle with req.
  - Both wrap modulo 2^32, reset to 0 asynchronously, and are not cleared by req.
- PIPE_STAGE_PERF_EN undefined: the counter ports and logic are absent. The datapath is otherwise identical.

## Test plan
- Reset: with DEPTH=2, assert reset between edges -> all out_* = 0 immediately, with no clock edge required. Deassert reset, drive in_valid=1, in_pc=0x3000, in_tnew=2 -> two edges later out_pc=0x3000, out_valid=1, out_tnew=0.
- Stall bubble: DEPTH=1, in_pc=0x3010, in_bd=1, in_ins=0x8C010004, stall=1 -> after the edge, out_ins=0, out_valid=0, out_tnew=0, out_pc=0x3010, out_bd=1.
- Flush priority: req=1, stall=1, hold=1 together -> after the edge, out_pc=0x4180, every other field 0. With the macro defined, flush_cnt=1 and bubble_cnt=0.
- Hold: DEPTH=3 with three valid instructions at PCs 0x3000/0x3004/0x3008 in flight. Hold for 4 cycles -> out_pc stays 0x3000 and out_tnew is unchanged. Release hold -> 0x3004 and 0x3008 emerge on the following two edges.
- Saturation: TW=3, DEPTH=4, in_tnew=0 -> out_tnew=0 after 4 edges. in_tnew=7 -> out_tnew=3.
- Counter wrap (macro defined): force bubble_cnt to 0xFFFFFFFF, apply one stall cycle -> bubble_cnt reads 0.
